// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared definitions for the CPU boot controller: state encoding, word widths
// and the register seed rule.
package cpu_boot_ctrl_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [2:0] {
        BOOT_IDLE = 3'd0,
        BOOT_LOAD = 3'd1,
        BOOT_INIT = 3'd2,
        BOOT_RUN  = 3'd3,
        BOOT_HALT = 3'd4
    } boot_state_e;

    // Seed value for register idx: zero in mode 0, the index itself otherwise (R0 is 0 either way).
    function automatic logic [WORD_W-1:0] reg_seed(input logic mode_index,
                                                   input logic [RF_ADDR_W-1:0] idx);
        return mode_index ? WORD_W'(idx) : '0;
    endfunction

endpackage

// File: rtl/cpu_boot_ctrl.sv
// Boot-and-run controller: streams the program into instruction memory, seeds the
// register file, then releases the CPU from reset for a bounded number of cycles.
module cpu_boot_ctrl
    import cpu_boot_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH    = 256,
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned REG_INIT_MODE = 1,
    parameter int unsigned RUN_CYCLES    = 40,
    parameter int unsigned CNT_W         = 16,
    localparam int unsigned ADDR_W       = $clog2(IMEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 load_valid,
    input  logic [WORD_W-1:0]    load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_W-1:0]    imem_wdata,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [WORD_W-1:0]    rf_wdata,
    input  logic                 halt_req,
    output logic                 cpu_reset,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycle_count
);

    boot_state_e          r_state;
    boot_state_e          w_state_nxt;
    logic [ADDR_W-1:0]    r_word_addr;
    logic [ADDR_W-1:0]    w_word_addr_nxt;
    logic [RF_ADDR_W-1:0] r_reg_idx;
    logic [RF_ADDR_W-1:0] w_reg_idx_nxt;
    logic [CNT_W-1:0]     r_cycle_count;
    logic [CNT_W-1:0]     w_cycle_count_nxt;
    logic [CNT_W-1:0]     w_cycle_inc;
    logic                 r_cpu_reset;

    assign w_cycle_inc = r_cycle_count + CNT_W'(1);

    // State and counter registers; CPU reset is low only while the next state is RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= BOOT_IDLE;
            r_word_addr   <= '0;
            r_reg_idx     <= '0;
            r_cycle_count <= '0;
            r_cpu_reset   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_word_addr   <= w_word_addr_nxt;
            r_reg_idx     <= w_reg_idx_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_cpu_reset   <= (w_state_nxt != BOOT_RUN);
        end
    end

    // Next-state, counter updates and per-state strobes.
    always_comb begin
        w_state_nxt       = r_state;
        w_word_addr_nxt   = r_word_addr;
        w_reg_idx_nxt     = r_reg_idx;
        w_cycle_count_nxt = r_cycle_count;
        load_ready        = 1'b0;
        imem_we           = 1'b0;
        rf_we             = 1'b0;
        running           = 1'b0;
        halted            = 1'b0;

        unique case (r_state)
            BOOT_IDLE: begin
                if (start) begin
                    w_state_nxt       = BOOT_LOAD;
                    w_word_addr_nxt   = '0;
                    w_reg_idx_nxt     = '0;
                    w_cycle_count_nxt = '0;
                end
            end
            BOOT_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    imem_we         = 1'b1;
                    w_word_addr_nxt = r_word_addr + ADDR_W'(1);
                    // The word written at the top address fills memory and ends the load.
                    if (load_last || (r_word_addr == ADDR_W'(IMEM_DEPTH - 1))) begin
                        w_state_nxt   = BOOT_INIT;
                        w_reg_idx_nxt = '0;
                    end
                end
            end
            BOOT_INIT: begin
                rf_we         = 1'b1;
                w_reg_idx_nxt = r_reg_idx + RF_ADDR_W'(1);
                if (r_reg_idx == RF_ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt       = BOOT_RUN;
                    w_cycle_count_nxt = '0;
                end
            end
            BOOT_RUN: begin
                running           = 1'b1;
                w_cycle_count_nxt = w_cycle_inc;
                if ((w_cycle_inc == CNT_W'(RUN_CYCLES)) || halt_req) begin
                    w_state_nxt = BOOT_HALT;
                end
            end
            BOOT_HALT: begin
                halted = 1'b1;
                if (start) begin
                    w_state_nxt       = BOOT_LOAD;
                    w_word_addr_nxt   = '0;
                    w_reg_idx_nxt     = '0;
                    w_cycle_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = BOOT_IDLE;
            end
        endcase
    end

    assign imem_addr   = r_word_addr;
    assign imem_wdata  = load_data;
    assign rf_waddr    = r_reg_idx;
    assign rf_wdata    = reg_seed(REG_INIT_MODE != 0, r_reg_idx);
    assign cpu_reset   = r_cpu_reset;
    assign cycle_count = r_cycle_count;

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Synthesizable boot-and-run controller for the MIPS32 CPU. It replaces bench-side hierarchical pokes ($readmemh into instruction memory, register file seeding, fixed run time) with hardware that does the same work.
- Streams program words into instruction memory over a valid/ready port.
- Seeds the register file through its write port.
- Releases the CPU from reset for a bounded number of cycles, then halts it.
- Sits between the external loader/bench and the CPU's instruction memory and register file write ports, and drives the CPU reset.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in words; the load address width is clog2(IMEM_DEPTH).
NUM_REGS, 32, number of register file entries to seed.
REG_INIT_MODE, 1, register seed value: 0 writes zero to every register; 1 writes reg[i]=i, with R0 always 0.
RUN_CYCLES, 40, maximum number of clock cycles the CPU is held out of reset.
CNT_W, 16, width of the run cycle counter; must satisfy RUN_CYCLES < 2^CNT_W.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins the load/init/run sequence
load_valid  in  1  load_data is valid
load_data  in  32  instruction word
load_last  in  1  qualifies the final word of the program
load_ready  out  1  controller accepts a word this cycle
imem_we  out  1  instruction memory write enable
imem_addr  out  clog2(IMEM_DEPTH)  instruction memory word address
imem_wdata  out  32  instruction memory write data
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
halt_req  in  1  early stop request, honoured only in RUN
cpu_reset  out  1  reset to the CPU, active-high
running  out  1  high while in RUN
halted  out  1  high while in HALT
cycle_count  out  CNT_W  number of RUN cycles elapsed

Behaviour:
- All control is on the rising edge of clock. reset is synchronous and active-high.
- Reset values: state=IDLE, word_addr=0, reg_idx=0, cycle_count=0, cpu_reset=1, all write enables=0, load_ready=0, running=0, halted=0.
- Reset asserted mid-operation aborts immediately. Any partially loaded memory contents are not cleared.
- States:
  - IDLE: cpu_reset=1. On start go to LOAD, clear word_addr and cycle_count.
  - LOAD: load_ready=1. A handshake occurs when load_valid & load_ready.
    - On a handshake: imem_we=1, imem_addr=word_addr, imem_wdata=load_data, all combinational in the same cycle. Then word_addr increments.
    - Exit to INIT when the handshake carries load_last=1, or when it is at word_addr=IMEM_DEPTH-1 (full). Words beyond depth are never accepted, and load_ready falls the next cycle.
    - Gaps in load_valid stall the controller with no writes.
  - INIT: one register write per cycle, rf_we=1, rf_waddr=reg_idx, for reg_idx = 0..NUM_REGS-1 (exactly NUM_REGS cycles).
    - rf_wdata = 0 when REG_INIT_MODE=0 or reg_idx=0; otherwise rf_wdata = reg_idx.
    - After the last write go to RUN and clear cycle_count.
  - RUN: cpu_reset=0, running=1, and cycle_count increments every cycle.
    - Exit to HALT at the end of the cycle in which cycle_count reaches RUN_CYCLES or halt_req=1 is sampled. That cycle counts.
    - RUN therefore lasts min(RUN_CYCLES, k) cycles, where k is the first halt_req cycle (1-based).
  - HALT: cpu_reset=1, halted=1, and cycle_count holds its value.
    - start returns to LOAD, clears counters and reloads the program.
- start is ignored in LOAD, INIT and RUN. halt_req is ignored outside RUN.
- cpu_reset is a registered output. It is low only in RUN cycles and goes high in the first HALT cycle.
- No write enable is ever asserted while cpu_reset=0.

Decomposition:
- Shared header constants.h gains the state encodings (BOOT_IDLE, BOOT_LOAD, BOOT_INIT, BOOT_RUN, BOOT_HALT) and the WORD_W=32 constant.
- No sub-module is needed; the FSM and three counters live in one module of about 150–250 lines.
- The CPU top level gains a write-port mux for instruction memory and the register file: the boot controller drives them while cpu_reset=1.

Test Plan:
1. Default parameters; start; 3 words {20100009, 00000000, 0000FFFF}, last on the 3rd.
   -> imem writes at addresses 0, 1, 2.
   -> 32 rf writes with rf_wdata=i (R0=0).
   -> cpu_reset low for exactly 40 cycles; halted=1; cycle_count=40.
2. IMEM_DEPTH=8; stream 10 words with no load_last.
   -> exactly 8 writes at addresses 0–7.
   -> load_ready=0 from the 9th offered word; INIT entered.
3. Toggle load_valid 1,0,0,1,1 with last on the final word.
   -> 3 writes at consecutive addresses 0, 1, 2; no write on idle cycles.
4. halt_req pulse in the 5th RUN cycle.
   -> cycle_count=5; cpu_reset high the next cycle; halted=1.
5. reset asserted during the 2nd INIT cycle.
   -> next cycle: IDLE, rf_we=0, cpu_reset=1, all counters 0.
   -> a subsequent start reloads correctly.
6. REG_INIT_MODE=0; start in HALT after a full run.
   -> new LOAD with word_addr=0; all rf_wdata=0; cycle_count restarts from 0.
